// File: rtl/prog_loader_if.sv
// Byte-stream receive and memory-write bus for the program loader.
// The loader sits on the slave side; the byte source and memory sit on master.
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Serial boot loader: parses framed bytes, writes data through to memory,
// and releases the CPU hold only after a frame with a good checksum.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          load_done,
  output logic          error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK
  } state_t;

  state_t        state, nxt;
  logic [15:0]   addr;
  logic [15:0]   cnt;
  logic [7:0]    sum;
  logic [TW-1:0] tcnt;
  logic          rxv;
  logic [7:0]    d;
  logic [7:0]    sum_nx;
  logic          tmo;

  assign rxv    = bus.rx_valid;
  assign d      = bus.rx_data;
  assign sum_nx = sum + d;
  // A gap of TIMEOUT_CYCLES idle clocks inside a frame aborts it
  assign tmo    = (state != S_IDLE) && !rxv && (tcnt == TMAX);

  always_comb begin
    nxt = state;
    if (tmo) begin
      nxt = S_IDLE;
    end else if (rxv) begin
      unique case (state)
        S_IDLE:    if (d == SYNC_BYTE) nxt = S_ADDR_HI;
        S_ADDR_HI: nxt = S_ADDR_LO;
        S_ADDR_LO: nxt = S_LEN_HI;
        S_LEN_HI:  nxt = S_LEN_LO;
        S_LEN_LO:  nxt = ({cnt[15:8], d} == 16'h0) ? S_CHECK : S_DATA;
        S_DATA:    if (cnt == 16'h1) nxt = S_CHECK;
        S_CHECK:   nxt = S_IDLE;
        default:   nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      addr          <= '0;
      cnt           <= '0;
      sum           <= '0;
      tcnt          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      error         <= 1'b0;
    end else begin
      state      <= nxt;
      bus.mem_we <= 1'b0;
      load_done  <= 1'b0;
      tcnt <= (rxv || tmo || state == S_IDLE) ? '0 : tcnt + 1'b1;
      if (tmo) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end else if (rxv) begin
        sum <= sum_nx;
        unique case (state)
          S_IDLE: begin
            sum <= '0;
            if (d == SYNC_BYTE) begin
              cpu_hold <= 1'b1;
              busy     <= 1'b1;
              error    <= 1'b0;
            end
          end
          S_ADDR_HI: addr[15:8] <= d;
          S_ADDR_LO: addr[7:0]  <= d;
          S_LEN_HI:  cnt[15:8]  <= d;
          S_LEN_LO:  cnt[7:0]   <= d;
          S_DATA: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr;
            bus.mem_wdata <= d;
            addr          <= addr + 16'h1;
            cnt           <= cnt - 16'h1;
          end
          S_CHECK: begin
            busy <= 1'b0;
            if (sum_nx == 8'h00) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
